instruction_fetch_unit: RTL and testbench

- Front-end stage directly upstream of the instruction buffer. Generates the fetch PC and issues in-order read requests to the instruction memory/MMU port.
- Collects returned words with their MMU status, queues them, and drives the buffer's iPREVIOUS_* inputs.
- Honours the buffer's fetch-stop and lock signals.
- Handles branch redirects from execute by discarding stale in-flight responses.

---
 rtl/instruction_fetch_unit.sv | 128 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch PC generation, in-order memory requests and a credit-limited
// response queue feeding the instruction buffer, with redirect flush of stale responses.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iBRANCH_VALID,
  input  logic [31:0] iBRANCH_ADDR,
  input  logic        iPAGING_ENA,
  input  logic        iKERNEL_ACCESS,
  input  logic        iPREDICT_TAKEN,
  input  logic [31:0] iPREDICT_ADDR,
  output logic        oMEM_REQ,
  output logic [31:0] oMEM_ADDR,
  input  logic        iMEM_ACK,
  input  logic        iMEM_VALID,
  input  logic [31:0] iMEM_DATA,
  input  logic        iMEM_PAGEFAULT,
  input  logic [13:0] iMEM_MMU_FLAGS,
  output logic        oNEXT_INST_VALID,
  output logic        oNEXT_PAGEFAULT,
  output logic [13:0] oNEXT_MMU_FLAGS,
  output logic        oNEXT_PAGING_ENA,
  output logic        oNEXT_KERNEL_ACCESS,
  output logic        oNEXT_BRANCH_PREDICT,
  output logic [31:0] oNEXT_BRANCH_PREDICT_ADDR,
  output logic [31:0] oNEXT_INST,
  output logic [31:0] oNEXT_PC,
  input  logic        iNEXT_FETCH_STOP,
  input  logic        iNEXT_LOCK
);
  localparam logic [1:0] FETCH = 2'd0, STOP = 2'd1, DRAIN = 2'd2;
  localparam logic [3:0] MAXC = 4'(MAX_OUTSTANDING);
  localparam logic [2:0] LAST = 3'(MAX_OUTSTANDING - 1);
  typedef struct packed {
    logic [31:0] pc;
    logic        paging;
    logic        kernel;
    logic        predict;
    logic [31:0] predict_addr;
  } tag_t;
  typedef struct packed {
    tag_t        tag;
    logic [31:0] inst;
    logic        pagefault;
    logic [13:0] flags;
  } entry_t;
  logic [1:0]  state, state_nx;
  logic [31:0] pc;
  logic [3:0]  credits, credits_nx, drop, drop_nx, tag_cnt, q_cnt, in_flight;
  logic [2:0]  tag_wr, tag_rd, q_wr, q_rd;
  logic        acc, keep, dropping, pop;
  tag_t        tag_mem [0:7];
  entry_t      q_mem [0:7];
  entry_t      head;

  function automatic logic [2:0] inc(input logic [2:0] p);
    return p == LAST ? 3'd0 : p + 3'd1;
  endfunction

  assign oMEM_REQ = state == FETCH && !iNEXT_FETCH_STOP && credits < MAXC && !iBRANCH_VALID;
  assign oMEM_ADDR = pc;
  assign acc = oMEM_REQ && iMEM_ACK;
  assign dropping = iMEM_VALID && drop != 4'd0;
  assign keep = iMEM_VALID && drop == 4'd0 && !iBRANCH_VALID;
  assign pop = q_cnt != 4'd0 && !iNEXT_LOCK && !iBRANCH_VALID;
  // A redirect dooms every accepted-but-unanswered request, minus the response landing this cycle
  assign in_flight = tag_cnt + drop + 4'(acc) - 4'(iMEM_VALID);
  assign drop_nx = drop - 4'(dropping);
  assign credits_nx = credits + 4'(acc) - 4'(dropping) - 4'(pop);
  assign state_nx = state == DRAIN ? (drop_nx == 4'd0 ? FETCH : DRAIN)
                  : (iNEXT_FETCH_STOP || credits_nx >= MAXC ? STOP : FETCH);
  assign head = q_cnt != 4'd0 ? q_mem[q_rd] : '0;
  assign oNEXT_INST_VALID = pop;
  assign {oNEXT_PC, oNEXT_PAGING_ENA, oNEXT_KERNEL_ACCESS, oNEXT_BRANCH_PREDICT,
          oNEXT_BRANCH_PREDICT_ADDR} = head.tag;
  assign oNEXT_INST = head.inst;
  assign oNEXT_PAGEFAULT = head.pagefault;
  assign oNEXT_MMU_FLAGS = head.flags;

  always_ff @(posedge iCLOCK) begin
    if (acc) tag_mem[tag_wr] <= {pc, iPAGING_ENA, iKERNEL_ACCESS, iPREDICT_TAKEN, iPREDICT_ADDR};
    if (keep) q_mem[q_wr] <= {tag_mem[tag_rd], iMEM_DATA, iMEM_PAGEFAULT, iMEM_MMU_FLAGS};
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state <= FETCH;
      pc <= RESET_VECTOR & 32'hFFFF_FFFC;
      credits <= '0;
      drop <= '0;
      tag_cnt <= '0;
      q_cnt <= '0;
      tag_wr <= '0;
      tag_rd <= '0;
      q_wr <= '0;
      q_rd <= '0;
    end else if (iBRANCH_VALID) begin
      state <= in_flight != 4'd0 ? DRAIN : FETCH;
      pc <= iBRANCH_ADDR & 32'hFFFF_FFFC;
      credits <= in_flight;
      drop <= in_flight;
      tag_cnt <= '0;
      q_cnt <= '0;
      tag_wr <= '0;
      tag_rd <= '0;
      q_wr <= '0;
      q_rd <= '0;
    end else begin
      state <= state_nx;
      credits <= credits_nx;
      drop <= drop_nx;
      tag_cnt <= tag_cnt + 4'(acc) - 4'(keep);
      q_cnt <= q_cnt + 4'(keep) - 4'(pop);
      if (acc) begin
        pc <= iPREDICT_TAKEN ? iPREDICT_ADDR & 32'hFFFF_FFFC : pc + 32'd4;
        tag_wr <= inc(tag_wr);
      end
      if (keep) begin
        tag_rd <= inc(tag_rd);
        q_wr <= inc(q_wr);
      end
      if (pop) q_rd <= inc(q_rd);
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized scoreboard bench; a behavioural fetch/memory model predicts
// the instruction stream, and a separate monitor pops and compares every delivered word.
module tb_instruction_fetch_unit;
  localparam int MAXO = 4;
  localparam logic [31:0] RV = 32'h100;
  logic clk = 0;
  always #5 clk = ~clk;
  logic        rst, br_valid, paging, kernel, pred, mem_ack, mem_valid, mem_pf, stop, lock;
  logic [31:0] br_addr, pred_addr, mem_data;
  logic [13:0] mem_flags;
  logic        req, nvalid, npf, npaging, nkernel, npred;
  logic [31:0] addr, npred_addr, ninst, npc;
  logic [13:0] nflags;

  instruction_fetch_unit #(.RESET_VECTOR(RV), .MAX_OUTSTANDING(MAXO)) dut (
    .iCLOCK(clk), .iRESET_SYNC(rst), .iBRANCH_VALID(br_valid), .iBRANCH_ADDR(br_addr),
    .iPAGING_ENA(paging), .iKERNEL_ACCESS(kernel), .iPREDICT_TAKEN(pred), .iPREDICT_ADDR(pred_addr),
    .oMEM_REQ(req), .oMEM_ADDR(addr), .iMEM_ACK(mem_ack), .iMEM_VALID(mem_valid),
    .iMEM_DATA(mem_data), .iMEM_PAGEFAULT(mem_pf), .iMEM_MMU_FLAGS(mem_flags),
    .oNEXT_INST_VALID(nvalid), .oNEXT_PAGEFAULT(npf), .oNEXT_MMU_FLAGS(nflags),
    .oNEXT_PAGING_ENA(npaging), .oNEXT_KERNEL_ACCESS(nkernel), .oNEXT_BRANCH_PREDICT(npred),
    .oNEXT_BRANCH_PREDICT_ADDR(npred_addr), .oNEXT_INST(ninst), .oNEXT_PC(npc),
    .iNEXT_FETCH_STOP(stop), .iNEXT_LOCK(lock)
  );

  typedef struct { logic [31:0] pc; logic [31:0] inst; logic [49:0] side; } exp_t;
  typedef struct { logic [31:0] data; logic pf; logic [13:0] flags; int due; } mem_t;
  exp_t exp_q[$];
  mem_t mem_q[$];
  int checks = 0, errors = 0;
  int cyc = 0, since_rst = 0, rst_cyc = 0, stale = 0;
  int p_ack = 0, p_lock = 0, p_stop = 0, p_branch = 0, p_pred = 0, lat = 1;
  bit force_br = 0, force_pf = 0, startup = 0;
  logic [31:0] force_addr = 0, model_pc = RV, pred_at = 32'h1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, want, cyc);
    end
  endfunction

  task automatic drive();
    bit hit;
    hit = addr == pred_at;
    br_valid = force_br || $urandom_range(99) < p_branch;
    br_addr = force_br ? force_addr : $urandom;
    lock = $urandom_range(99) < p_lock;
    stop = $urandom_range(99) < p_stop;
    mem_ack = !rst && $urandom_range(99) < p_ack;
    paging = 1'($urandom_range(1));
    kernel = 1'($urandom_range(1));
    pred = hit || $urandom_range(99) < p_pred;
    pred_addr = hit ? 32'h2003 : $urandom;
    mem_valid = !rst && mem_q.size() > 0 && mem_q[0].due <= cyc;
    mem_data = mem_valid ? mem_q[0].data : $urandom;
    mem_pf = mem_valid ? mem_q[0].pf : 1'($urandom_range(1));
    mem_flags = mem_valid ? mem_q[0].flags : 14'($urandom);
  endtask

  task automatic sample();
    mem_t m;
    exp_t e;
    bit acc;
    if (rst) begin
      exp_q.delete();
      mem_q.delete();
      stale = 0;
      model_pc = RV;
      since_rst = 0;
      if (rst_cyc > 0) begin
        chk("rst_valid", 64'(nvalid), 64'(0));
        chk("rst_addr", 64'(addr), 64'(RV));
        chk("rst_next_pc", 64'(npc), 64'(0));
        chk("rst_next_inst", 64'(ninst), 64'(0));
      end
      rst_cyc++;
      cyc++;
      return;
    end
    rst_cyc = 0;
    acc = req && mem_ack;
    if (startup) chk("startup_stream", 64'(nvalid), 64'(since_rst >= 2));
    if (br_valid || stale > 0) chk("req_in_redirect_or_drain", 64'(req), 64'(0));
    if (stop) chk("req_in_fetch_stop", 64'(req), 64'(0));
    if (acc) chk("credit_limit", 64'(exp_q.size() + int'(nvalid) + stale < MAXO), 64'(1));
    if (mem_valid) begin
      m = mem_q.pop_front();
      if (stale > 0) stale--;
    end
    if (acc) begin
      chk("fetch_addr", 64'(addr), 64'(model_pc));
      m.data = $urandom;
      m.pf = force_pf || $urandom_range(1) == 1;
      m.flags = force_pf ? 14'h0009 : 14'($urandom);
      m.due = cyc + lat;
      mem_q.push_back(m);
      e.pc = model_pc;
      e.inst = m.data;
      e.side = {m.pf, m.flags, paging, kernel, pred, pred_addr};
      exp_q.push_back(e);
      model_pc = pred ? {pred_addr[31:2], 2'b00} : model_pc + 32'd4;
    end
    if (br_valid) begin
      exp_q.delete();
      model_pc = {br_addr[31:2], 2'b00};
      stale = mem_q.size();
    end
    since_rst++;
    cyc++;
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    #1;
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic redirect(input logic [31:0] a);
    force_br = 1;
    force_addr = a;
    cycle();
    force_br = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (lock || br_valid) chk("hold_on_lock_or_redirect", 64'(nvalid), 64'(0));
        if (nvalid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual pc=%h required no output", npc);
          end else begin
            e = exp_q.pop_front();
            chk("out_pc", 64'(npc), 64'(e.pc));
            chk("out_inst", 64'(ninst), 64'(e.inst));
            chk("out_side", 64'({npf, nflags, npaging, nkernel, npred, npred_addr}), 64'(e.side));
          end
        end
      end
    end
  end

  initial begin
    rst = 1;
    {br_valid, paging, kernel, pred, mem_ack, mem_valid, mem_pf, stop, lock} = '0;
    {br_addr, pred_addr, mem_data} = '0;
    mem_flags = '0;
    @(posedge clk);
    #1;
    run(3);
    rst = 0;
    p_ack = 100;
    pred_at = 32'h108;
    startup = 1;
    run(20);
    startup = 0;
    pred_at = 32'h1;
    p_lock = 100;
    run(10);
    chk("lock_fill", 64'(exp_q.size()), 64'(MAXO));
    p_lock = 0;
    run(10);
    lat = 3;
    run(8);
    redirect(32'h4000);
    run(15);
    p_stop = 100;
    run(6);
    p_stop = 0;
    run(8);
    lat = 2;
    force_pf = 1;
    redirect(32'hFFFF_FFF8);
    run(12);
    force_pf = 0;
    redirect(32'h8000);
    redirect(32'h9006);
    run(12);
    p_ack = 70;
    p_lock = 20;
    p_stop = 15;
    p_branch = 4;
    p_pred = 15;
    for (int k = 0; k < 12; k++) begin
      lat = $urandom_range(4, 1);
      run(50);
    end
    rst = 1;
    run(3);
    rst = 0;
    run(100);
    p_ack = 0;
    p_lock = 0;
    p_stop = 0;
    p_branch = 0;
    run(30);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
